// File: rtl/ans_pkg.sv
// Shared types and constants for the ans threshold comparator.
// The ripple state carried between per-bit slices is kept here.
package ans_pkg;

    localparam int DEFAULT_WIDTH = 3;
    // 17201046 mod 7
    localparam logic [2:0] LAB_CRUX = 3'b010;

    typedef struct packed {
        logic decided;
        logic greater;
    } cmp_state_t;

endpackage

// File: rtl/ans_cmp_slice.sv
// One bit of the MSB-first magnitude compare ripple.
// The first differing bit decides the outcome; later bits pass it through.
module ans_cmp_slice
    import ans_pkg::*;
(
    input  logic       i_xi,
    input  logic       i_ci,
    input  cmp_state_t i_st,
    output cmp_state_t o_st
);

    always_comb begin
        o_st = i_st;
        if (!i_st.decided && (i_xi != i_ci)) begin
            o_st.decided = 1'b1;
            o_st.greater = i_xi;
        end
    end

endmodule

// File: rtl/ans.sv
// Registered unsigned comparator: result = (x > crux), one cycle latency.
// Built as a ripple of per-bit slices feeding a synchronously reset flop.
module ans
    import ans_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] crux,
    output logic             result
);

    // w_st[i+1] enters slice i; w_st[WIDTH] is the state above the MSB
    cmp_state_t w_st [WIDTH:0];
    logic       w_gt;
    logic       r_result;

    assign w_st[WIDTH] = '0;

    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
        ans_cmp_slice u_slice (
            .i_xi (x[i]),
            .i_ci (crux[i]),
            .i_st (w_st[i+1]),
            .o_st (w_st[i])
        );
    end

    assign w_gt = w_st[0].decided & w_st[0].greater;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 1'b0;
        end else begin
            r_result <= w_gt;
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_ans.sv
// Directed self-checking bench for ans at WIDTH=3 and WIDTH=8.
module tb_ans;
    import ans_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] x3, c3;
    logic [7:0] x8, c8;
    logic       res3, res8;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    ans #(.WIDTH(3)) dut3 (
        .clk    (clk),
        .rst    (rst),
        .x      (x3),
        .crux   (c3),
        .result (res3)
    );

    ans #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .x      (x8),
        .crux   (c8),
        .result (res8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] sweep_exp;
        logic       ex;

        rst = 1'b1;
        x3 = 3'b111;
        c3 = 3'b000;
        x8 = 8'hff;
        c8 = 8'h00;

        // reset held two edges, then released
        tick();
        chk("rst_edge1", res3, 1'b0);
        chk("rst_edge1_w8", res8, 1'b0);
        tick();
        chk("rst_edge2", res3, 1'b0);
        rst = 1'b0;
        tick();
        chk("rst_release", res3, 1'b1);
        chk("rst_release_w8", res8, 1'b1);

        // lab sweep, crux = 2: expected 0,0,0,1,1,1,1,1
        sweep_exp = 8'b1111_1000;
        c3 = LAB_CRUX;
        for (int i = 0; i < 8; i++) begin
            x3 = 3'(i);
            tick();
            chk($sformatf("lab_x%0d", i), res3, sweep_exp[i]);
        end

        // equality edges
        c3 = 3'b000; x3 = 3'd0; tick(); chk("c0_x0", res3, 1'b0);
        x3 = 3'd1;               tick(); chk("c0_x1", res3, 1'b1);
        c3 = 3'b111; x3 = 3'd7; tick(); chk("c7_x7", res3, 1'b0);
        x3 = 3'd6;               tick(); chk("c7_x6", res3, 1'b0);

        // MSB dominance
        x3 = 3'b100; c3 = 3'b011; tick(); chk("msb_gt", res3, 1'b1);
        x3 = 3'b011; c3 = 3'b100; tick(); chk("msb_lt", res3, 1'b0);

        // back-to-back with a one-cycle mid-stream reset
        c3 = 3'd2;
        x3 = 3'd3; tick(); chk("bb0", res3, 1'b1);
        x3 = 3'd1; tick(); chk("bb1", res3, 1'b0);
        x3 = 3'd3; tick(); chk("bb2", res3, 1'b1);
        x3 = 3'd1; tick(); chk("bb3", res3, 1'b0);
        x3 = 3'd3; rst = 1'b1; tick(); chk("bb_rst", res3, 1'b0);
        rst = 1'b0;
        x3 = 3'd3; tick(); chk("bb4", res3, 1'b1);
        x3 = 3'd1; tick(); chk("bb5", res3, 1'b0);
        x3 = 3'd3; tick(); chk("bb6", res3, 1'b1);

        // exhaustive WIDTH=3
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                x3 = 3'(a);
                c3 = 3'(b);
                ex = (a > b);
                tick();
                chk($sformatf("ex3_%0d_%0d", a, b), res3, ex);
            end
        end

        // WIDTH=8 boundaries
        x8 = 8'hff; c8 = 8'hff; tick(); chk("w8_eq_max", res8, 1'b0);
        x8 = 8'hfe;             tick(); chk("w8_max_c", res8, 1'b0);
        x8 = 8'h00; c8 = 8'h00; tick(); chk("w8_zero", res8, 1'b0);
        x8 = 8'h01;             tick(); chk("w8_c0_x1", res8, 1'b1);
        x8 = 8'h80; c8 = 8'h7f; tick(); chk("w8_msb_gt", res8, 1'b1);
        x8 = 8'h7f; c8 = 8'h80; tick(); chk("w8_msb_lt", res8, 1'b0);

        // WIDTH=8 random pairs
        for (int k = 0; k < 200; k++) begin
            int unsigned ra, rb;
            ra = $urandom_range(255);
            rb = (k % 5 == 0) ? ra : $urandom_range(255);
            x8 = 8'(ra);
            c8 = 8'(rb);
            ex = (ra > rb);
            tick();
            chk($sformatf("rnd8_%0d_%0d", ra, rb), res8, ex);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ans.md
Name: ans

Overview:
- Registered unsigned magnitude comparator.
- Each clock it compares the input word `x` against a threshold word `crux` and flags whether `x` is strictly greater than `crux`.
- Used as a threshold detector. Lab configuration: `crux` = 3'b010, which is 2, derived as 17201046 mod 7.
- The comparison is built as a ripple of per-bit slices evaluated MSB to LSB, followed by an output register.

Parameters:
- WIDTH, default 3: bit width of `x` and `crux`; legal range 1 to 32.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      synchronous reset, active-high
- x      input   WIDTH  operand; bit WIDTH-1 is the MSB; for WIDTH=3 the bits are named x, y, z from MSB to LSB
- crux   input   WIDTH  threshold operand, unsigned
- result output  1      registered flag: 1 when x > crux (unsigned)

Behaviour:
- Reset and clocking:
  - One clock domain; reset is synchronous and active-high.
  - While `rst` is 1 at a rising edge of `clk`, `result` is 0 on the next cycle. The reset value of `result` is 0.
  - Reset has priority over the compare update at the same edge.
- Combinational compare:
  - gt = 1 iff unsigned(x) > unsigned(crux).
  - Equal operands give gt = 0.
  - There is no sign interpretation: all-ones is the largest value.
- Ripple structure, scanning from MSB down to LSB:
  - Carry a pair (decided, greater), initialised to (0, 0) above the MSB.
  - At bit i, if not yet decided and x[i] != crux[i]: set decided = 1 and greater = x[i].
  - Once decided, lower bits do not change the outcome.
  - After the LSB, gt = greater. Operands that never differ give gt = 0.
- Latency:
  - `result` is registered.
  - Inputs sampled at edge N appear on `result` after edge N. The outputs are stable for the whole following cycle.
  - Latency is 1 cycle, with a new comparison every cycle and no handshake.
- Input changes:
  - `x` and `crux` may change every cycle independently; only values present at the rising edge matter.
  - A change of `crux` mid-stream takes effect on the next edge, like any input.
- Boundary conditions:
  - x = crux gives 0.
  - x = 0 always gives 0.
  - crux = 2^WIDTH-1 always gives 0.
  - crux = 0 gives 1 for every nonzero x.
- Reset mid-operation:
  - Any in-flight result is discarded and `result` = 0.
  - The first valid compare appears one edge after `rst` is deasserted.
- Unknown inputs: X or Z on the inputs is not required to be handled; no assertions are built into the RTL.
- The design is fully synchronous: no latches and no combinational path from inputs to `result`.

Decomposition:
- Shared package `ans_pkg`:
  - localparam DEFAULT_WIDTH = 3
  - localparam LAB_CRUX = 3'b010, the bench constant for 17201046 mod 7
  - typedef cmp_state_t: a struct holding logic decided and logic greater.
- Sub-module `ans_cmp_slice`:
  - One per bit, instantiated in a generate loop from MSB to LSB.
  - Inputs: xi, ci, and an incoming cmp_state_t.
  - Output: the outgoing cmp_state_t.
  - Purely combinational.
- Top level `ans`: owns the generate chain, the final gt extraction, and the reset-able output flop.

Test Plan:
- Reset: assert `rst` for 2 edges with x = 3'b111, crux = 3'b000 -> `result` = 0 throughout reset; `result` = 1 one edge after `rst` is released.
- Lab sweep: crux = 3'b010, x stepped 0..7 every 10 time units, one value per clock -> `result` sequence 0,0,0,1,1,1,1,1, each value one cycle after its x.
- Equality edges: crux = 3'b000 with x = 0 -> 0, and x = 1 -> 1. Then crux = 3'b111 with x = 7 -> 0, and x = 6 -> 0.
- MSB dominance: x = 3'b100, crux = 3'b011 -> 1. Then x = 3'b011, crux = 3'b100 -> 0, proving lower bits do not override the first differing bit.
- Back-to-back and mid-stream reset: alternate x between 3 and 1 each cycle with crux = 2 -> `result` alternates 1,0 with 1-cycle latency. Assert `rst` for one cycle mid-stream -> `result` = 0 on that cycle, and the toggling resumes afterwards.
- Exhaustive check: for WIDTH=3, all 64 (x, crux) pairs -> `result` equals (x > crux) one cycle later. Repeat with WIDTH=8 using random pairs.
